// File: rtl/rf_pkg.sv
// Shared register-file constants and the write-back requester encoding.
// Pure type/constant package; no logic, no latency, no flow control.
package rf_pkg;
    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 4;
    localparam int RF_NREGS  = 16;

    typedef enum logic {
        WB_MEM = 1'b0,
        WB_ALU = 1'b1
    } wb_src_t;
endpackage

// File: rtl/wb_slot.sv
// One-entry holding register for a write-back requester.
// Latency: loads at the transfer edge; ready = empty or being drained this cycle.
module wb_slot #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] data,
    input  logic              grant,
    output logic              ready,
    output logic              hold_v,
    output logic [ADDR_W-1:0] hold_rd,
    output logic [DATA_W-1:0] hold_data
);
    assign ready = !rst && (!hold_v || grant);

    // A refill at the same edge as the drain keeps the slot full.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v    <= 1'b0;
            hold_rd   <= '0;
            hold_data <= '0;
        end else if (valid && ready) begin
            hold_v    <= 1'b1;
            hold_rd   <= rd;
            hold_data <= data;
        end else if (grant) begin
            hold_v    <= 1'b0;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter of ALU/load results onto the single register-file write port, plus busy scoreboard.
// Latency: transfer at edge k -> wr during k+1..k+2 (one extra cycle when losing arbitration).
// Backpressure: each requester stalls only while its slot is full and not granted.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_rd,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_rd,
    output logic                 wr,
    output logic [ADDR_W-1:0]    Rd,
    output logic [DATA_W-1:0]    RW,
    output logic [2**ADDR_W-1:0] busy
);
    logic              alu_hv, mem_hv;
    logic [ADDR_W-1:0] alu_hrd, mem_hrd;
    logic [DATA_W-1:0] alu_hdata, mem_hdata;
    logic              grant_alu, grant_mem;
    wb_src_t           rr;
    logic [2**ADDR_W-1:0] busy_nxt;

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu (
        .clk(clk), .rst(rst), .valid(alu_valid), .rd(alu_rd), .data(alu_data),
        .grant(grant_alu), .ready(alu_ready),
        .hold_v(alu_hv), .hold_rd(alu_hrd), .hold_data(alu_hdata)
    );

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clk(clk), .rst(rst), .valid(mem_valid), .rd(mem_rd), .data(mem_data),
        .grant(grant_mem), .ready(mem_ready),
        .hold_v(mem_hv), .hold_rd(mem_hrd), .hold_data(mem_hdata)
    );

    // Grants look only at slot state, keeping ready free of any valid input.
    always_comb begin
        grant_alu = !rst && alu_hv && (!mem_hv || rr == WB_ALU);
        grant_mem = !rst && mem_hv && (!alu_hv || rr == WB_MEM);
    end

    // Issue set is applied after the write clear so it wins on a collision.
    always_comb begin
        busy_nxt = busy;
        if (wr)
            busy_nxt[Rd] = 1'b0;
        if (issue_valid)
            busy_nxt[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr   <= 1'b0;
            Rd   <= '0;
            RW   <= '0;
            rr   <= WB_MEM;
            busy <= '0;
        end else begin
            wr   <= grant_alu || grant_mem;
            busy <= busy_nxt;
            if (grant_alu) begin
                Rd <= alu_hrd;
                RW <= alu_hdata;
                rr <= WB_MEM;
            end else if (grant_mem) begin
                Rd <= mem_hrd;
                RW <= mem_hdata;
                rr <= WB_ALU;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a cycle-level reference model.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, issue_valid;
    logic        alu_ready, mem_ready;
    logic [3:0]  alu_rd, mem_rd, issue_rd;
    logic [15:0] alu_data, mem_data;
    logic        wr;
    logic [3:0]  Rd;
    logic [15:0] RW;
    logic [15:0] busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: per-requester pending entry, fairness pointer, write port, scoreboard.
    bit          p_v  [2];
    logic [3:0]  p_rd [2];
    logic [15:0] p_dat[2];
    int          last_served;     // requester that must yield on the next tie (0 = mem, 1 = alu)
    bit          e_wr;
    logic [3:0]  e_rd;
    logic [15:0] e_rw;
    logic [15:0] e_busy;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wr(wr), .Rd(Rd), .RW(RW), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check readies, clock, advance the model, check outputs.
    task automatic step(input logic r,
                        input logic av, input logic [3:0] ard, input logic [15:0] adat,
                        input logic mv, input logic [3:0] mrd, input logic [15:0] mdat,
                        input logic iv, input logic [3:0] ird);
        int winner;
        bit rdy[2];
        bit vin[2];
        logic [3:0]  rd_in[2];
        logic [15:0] dat_in[2];
        rst = r;
        alu_valid = av; alu_rd = ard; alu_data = adat;
        mem_valid = mv; mem_rd = mrd; mem_data = mdat;
        issue_valid = iv; issue_rd = ird;
        vin[0] = mv; rd_in[0] = mrd; dat_in[0] = mdat;
        vin[1] = av; rd_in[1] = ard; dat_in[1] = adat;
        #2;
        winner = -1;
        if (!r) begin
            if (p_v[0] && p_v[1]) winner = 1 - last_served;
            else if (p_v[0])      winner = 0;
            else if (p_v[1])      winner = 1;
        end
        for (int s = 0; s < 2; s++)
            rdy[s] = !r && (!p_v[s] || winner == s);
        chk("mem_ready", {31'b0, mem_ready}, {31'b0, rdy[0]});
        chk("alu_ready", {31'b0, alu_ready}, {31'b0, rdy[1]});
        @(posedge clk);
        if (r) begin
            p_v[0] = 0; p_v[1] = 0;
            last_served = 1;
            e_wr = 0; e_rd = '0; e_rw = '0; e_busy = '0;
        end else begin
            if (e_wr) e_busy[e_rd] = 1'b0;
            if (iv)   e_busy[ird]  = 1'b1;
            e_wr = (winner >= 0);
            if (winner >= 0) begin
                e_rd = p_rd[winner];
                e_rw = p_dat[winner];
                p_v[winner] = 0;
                last_served = winner;
            end
            for (int s = 0; s < 2; s++)
                if (vin[s] && rdy[s]) begin
                    p_v[s] = 1; p_rd[s] = rd_in[s]; p_dat[s] = dat_in[s];
                end
        end
        #1;
        chk("wr",   {31'b0, wr}, {31'b0, e_wr});
        chk("Rd",   {28'b0, Rd}, {28'b0, e_rd});
        chk("RW",   {16'b0, RW}, {16'b0, e_rw});
        chk("busy", {16'b0, busy}, {16'b0, e_busy});
    endtask

    task automatic idle();
        step(0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0);
    endtask

    task automatic do_reset();
        step(1, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0);
    endtask

    initial begin
        logic [3:0] prev_rd;
        rst = 1'b1;
        alu_valid = 0; mem_valid = 0; issue_valid = 0;
        alu_rd = '0; mem_rd = '0; issue_rd = '0; alu_data = '0; mem_data = '0;
        last_served = 1;
        e_wr = 0; e_rd = '0; e_rw = '0; e_busy = '0;
        p_v[0] = 0; p_v[1] = 0;

        // Reset with traffic and an issue held active.
        step(1, 1, 4'd1, 16'h1234, 0, 4'd0, 16'h0, 1, 4'd3);
        step(1, 1, 4'd1, 16'h1234, 0, 4'd0, 16'h0, 1, 4'd3);
        chk("rst_wr", {31'b0, wr}, 32'd0);
        chk("rst_busy", {16'b0, busy}, 32'h0000);
        chk("rst_alu_ready", {31'b0, alu_ready}, 32'd0);
        chk("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
        chk("rst_Rd", {28'b0, Rd}, 32'd0);
        chk("rst_RW", {16'b0, RW}, 32'd0);
        idle();

        // Single write to r5.
        step(0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 1, 4'd5);
        chk("sw_busy5_set", {31'b0, busy[5]}, 32'd1);
        step(0, 1, 4'd5, 16'hBEEF, 0, 4'd0, 16'h0, 0, 4'd0);
        idle();
        chk("sw_wr", {31'b0, wr}, 32'd1);
        chk("sw_Rd", {28'b0, Rd}, 32'd5);
        chk("sw_RW", {16'b0, RW}, 32'hBEEF);
        idle();
        chk("sw_busy5_clr", {31'b0, busy[5]}, 32'd0);

        // Contention right after reset: mem first.
        do_reset();
        step(0, 1, 4'd4, 16'h2222, 1, 4'd2, 16'h1111, 0, 4'd0);
        idle();
        chk("ct_first_Rd", {28'b0, Rd}, 32'd2);
        chk("ct_first_RW", {16'b0, RW}, 32'h1111);
        idle();
        chk("ct_second_Rd", {28'b0, Rd}, 32'd4);
        chk("ct_second_RW", {16'b0, RW}, 32'h2222);
        idle();

        // Continuous contention: mem uses r1, alu uses r8.
        step(0, 1, 4'd8, 16'hA000, 1, 4'd1, 16'hB000, 0, 4'd0);
        prev_rd = 4'd0;
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 4'd8, 16'hA000 + 16'(i), 1, 4'd1, 16'hB000 + 16'(i), 0, 4'd0);
            chk("cc_wr", {31'b0, wr}, 32'd1);
            if (i > 1) chk("cc_alternate", {31'b0, Rd == prev_rd}, 32'd0);
            prev_rd = Rd;
        end
        idle(); idle(); idle();

        // Issue to r7 at the edge where the earlier r7 write completes.
        step(0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 1, 4'd7);
        step(0, 1, 4'd7, 16'h0777, 0, 4'd0, 16'h0, 0, 4'd0);
        idle();
        chk("sc_wr_r7", {31'b0, wr && Rd == 4'd7}, 32'd1);
        step(0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 1, 4'd7);
        chk("sc_busy7", {31'b0, busy[7]}, 32'd1);

        // Same destination from both requesters.
        do_reset();
        step(0, 1, 4'd9, 16'h00BB, 1, 4'd9, 16'h00AA, 0, 4'd0);
        idle();
        chk("sd_first_RW", {16'b0, RW}, 32'h00AA);
        idle();
        chk("sd_last_RW", {16'b0, RW}, 32'h00BB);
        chk("sd_last_wr", {31'b0, wr}, 32'd1);
        idle();

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 1'($urandom), 4'($urandom), 16'($urandom),
                 1'($urandom), 4'($urandom), 16'($urandom),
                 1'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 16 x 16-bit register file. Two writers, the ALU and the load/store unit, share the register file's single write port (`wr`, `Rd`, `RW`). Each writer gets a one-entry holding slot and fair round-robin arbitration. A 16-bit busy scoreboard marks destination registers with a write still in flight, so the issue stage can stall on read-after-write hazards.

## Interface
Parameters:
- `DATA_W`, 16, write data width; matches the register file width.
- `ADDR_W`, 4, register address width; 2^ADDR_W registers.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU has a result to write.
- `alu_ready`  out  1  ALU slot can accept this cycle.
- `alu_rd`  in  ADDR_W  ALU destination register.
- `alu_data`  in  DATA_W  ALU result.
- `mem_valid`  in  1  load/store unit has load data to write.
- `mem_ready`  out  1  load/store slot can accept this cycle.
- `mem_rd`  in  ADDR_W  load destination register.
- `mem_data`  in  DATA_W  load data.
- `issue_valid`  in  1  an instruction that writes `issue_rd` has issued.
- `issue_rd`  in  ADDR_W  destination register of the issued instruction.
- `wr`  out  1  register-file write enable, registered.
- `Rd`  out  ADDR_W  register-file write address, registered.
- `RW`  out  DATA_W  register-file write data, registered.
- `busy`  out  2^ADDR_W  scoreboard; bit i = write to register i pending.

## Operation
- Requester slots:
  - `alu` and `mem` each own a holding register: `hold_v`, `hold_rd`, `hold_data`.
  - A transfer occurs when `x_valid & x_ready`; it loads the slot at the clock edge.
  - `x_ready = !rst & (!hold_v | grant_x)`, so a granted slot accepts a new entry in the same cycle (full throughput).
- Arbitration (combinational, on slot state only):
  - One valid slot: that slot is granted.
  - Both slots valid: the slot named by the round-robin pointer `rr` is granted.
  - After every grant, `rr` points to the other requester.
  - Only a double-valid cycle actually needs the pointer; a single-valid grant still flips it.
- Write port:
  - On the edge after a grant: `wr <= 1`, `Rd <= hold_rd`, `RW <= hold_data`, and the granted slot clears unless it is refilled at the same edge.
  - No grant: `wr <= 0`; `Rd` and `RW` hold their previous values.
- Scoreboard:
  - At each edge, `busy[issue_rd]` is set if `issue_valid`.
  - At each edge, `busy[Rd]` is cleared if `wr`; this is the edge at which the register file captures the write.
  - Set and clear of the same index at the same edge: set wins.
  - Setting an already-busy bit is legal; it stays 1.
- Same destination from both requesters: both writes occur, in grant order, and the last write wins in the register file.
- The block does no hazard checking of its own; the issue stage owns the stall on `busy`.

## Timing
- Reset, at the edge with `rst` high, clears:
  - `wr = 0`, `Rd = 0`, `RW = 0`, `busy = 0`.
  - Both `hold_v = 0`.
  - `rr` = `mem` (loads have first priority after reset).
- While `rst` is high:
  - `alu_ready` and `mem_ready` are 0.
  - Any in-flight slot contents are discarded; there is no write.
- Latency from transfer at edge k with the other slot idle:
  - Grant during cycle k..k+1.
  - `wr` high during cycle k+1..k+2.
  - Register file captures at edge k+2.
  - `busy` bit clears at edge k+2.
- Contention: the losing slot waits exactly one cycle, since the pointer guarantees it the next grant. Worst-case transfer-to-`wr` latency is 2 cycles.
- Sustained throughput: one write per cycle total, split 1:1 under continuous contention.
- `x_ready` depends combinationally on `x_valid` of neither requester. There is no combinational path from any input to `wr`, `Rd` or `RW`.

## Structure
- Shared package `rf_pkg` holds:
  - `RF_DATA_W = 16`, `RF_ADDR_W = 4`, `RF_NREGS = 16`.
  - Requester enum `wb_src_t {WB_MEM, WB_ALU}`, used for `rr`.
- Sub-module `wb_slot`: one holding register with its valid/ready logic. It is instantiated twice (`alu`, `mem`).
- Arbiter, write-port registers and scoreboard live in the top module.

## Test plan
- Reset:
  - Setup: drive `alu_valid = 1` and `issue_valid = 1` (rd 3) during `rst`.
  - Required: `wr = 0`, `busy = 16'h0000`, both readies 0; first post-reset cycle both readies are 1.
- Single write:
  - Stimulus: `issue_rd = 5` at edge 0, then ALU transfers rd 5, data 16'hBEEF at edge 1.
  - Required: `busy[5] = 1` from edge 0; `wr = 1`, `Rd = 5`, `RW = 16'hBEEF` in cycle 2; `busy[5] = 0` after edge 3.
- Contention after reset:
  - Stimulus: both transfer in the same cycle (mem rd 2 data 16'h1111, alu rd 4 data 16'h2222).
  - Required: mem write first, alu write on the next cycle, `alu_ready = 0` for exactly one cycle.
- Continuous contention for 8 cycles:
  - Required: 8 consecutive `wr` pulses, strictly alternating sources, no lost or duplicated data.
- Same-edge set/clear:
  - Stimulus: `issue_rd = 7` at the edge where a pending write to register 7 completes.
  - Required: `busy[7]` stays 1.
- Same destination:
  - Stimulus: both requesters write rd 9 (mem 16'h00AA, alu 16'h00BB) simultaneously after reset.
  - Required: two writes, final `RW` on the last pulse = 16'h00BB.
